// File: rtl/dmem_pkg.sv
// Shared decode constants for the data-side memory responder: MMIO register
// offsets, address region classification and STATUS register bit layout.
package dmem_pkg;

    localparam logic [31:0] OFF_TOHOST   = 32'h00;
    localparam logic [31:0] OFF_CONSOLE  = 32'h04;
    localparam logic [31:0] OFF_STATUS   = 32'h08;
    localparam logic [31:0] OFF_MTIME_LO = 32'h0C;
    localparam logic [31:0] OFF_MTIME_HI = 32'h10;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_t;

    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_FULL_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;
    localparam int STATUS_COUNT_LSB = 4;

    // Only the five register offsets exist inside the MMIO window; any other
    // address outside RAM falls through to unmapped.
    function automatic region_t decode_region(input logic [31:0] addr,
                                              input logic [31:0] mmio_base,
                                              input logic [31:0] ram_bytes);
        logic [31:0] off;
        off = addr - mmio_base;
        if (addr < ram_bytes)
            return REG_RAM;
        if ((addr >= mmio_base) &&
            (off == OFF_TOHOST || off == OFF_CONSOLE || off == OFF_STATUS ||
             off == OFF_MTIME_LO || off == OFF_MTIME_HI))
            return REG_MMIO;
        return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Console TX FIFO: synchronous, power-of-two depth, no write-to-read bypass,
// sticky overflow flag when a push finds it full with no pop in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot this push needs, so full-with-pop still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst && do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: combinational loads from word RAM and MMIO
// (tohost, STATUS, mtime with coherent high shadow); stores and MMIO state on the clock edge.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready,
    output logic        test_done,
    output logic [31:0] test_code,
    output logic        access_fault,
    output logic        fifo_overflow
);

    localparam logic [31:0] RAM_BYTES = 32'd4 << ADDR_W;
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [2**ADDR_W];
    logic [63:0]       mtime;
    logic [31:0]       mtime_hi_shadow;
    region_t           region;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              rd_ok;
    logic              wr_ok;
    logic              is_mmio;
    logic              ram_we;
    logic              tohost_we;
    logic              console_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       status_word;

    assign region     = decode_region(address, MMIO_BASE, RAM_BYTES);
    assign offset     = address - MMIO_BASE;
    assign word_idx   = address[ADDR_W+1:2];
    assign misaligned = (address[1:0] != 2'b00);
    assign is_mmio    = (region == REG_MMIO);
    assign rd_ok      = mem_read && !misaligned;
    // Writes during a reset cycle are discarded along with all other state.
    assign wr_ok        = mem_write && !misaligned && rst;
    assign ram_we       = wr_ok && (region == REG_RAM);
    assign tohost_we    = wr_ok && is_mmio && (offset == OFF_TOHOST);
    assign console_push = wr_ok && is_mmio && (offset == OFF_CONSOLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (console_push),
        .push_data (mem_write_data[7:0]),
        .pop       (console_ready),
        .head      (console_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_overflow)
    );

    assign console_valid = !fifo_empty;

    always_comb begin
        status_word                               = '0;
        status_word[STATUS_COUNT_LSB +: 4]        = 4'(fifo_count);
        status_word[STATUS_OVF_BIT]               = fifo_overflow;
        status_word[STATUS_FULL_BIT]              = fifo_full;
        status_word[STATUS_EMPTY_BIT]             = fifo_empty;
    end

    always_comb begin
        mem_read_data = '0;
        if (rd_ok) begin
            if (region == REG_RAM) begin
                mem_read_data = ram[word_idx];
            end else if (is_mmio) begin
                case (offset)
                    OFF_TOHOST:   mem_read_data = test_code;
                    OFF_STATUS:   mem_read_data = status_word;
                    OFF_MTIME_LO: mem_read_data = mtime[31:0];
                    OFF_MTIME_HI: mem_read_data = mtime_hi_shadow;
                    default:      mem_read_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we)
            ram[word_idx] <= mem_write_data;
    end

    // A MTIME_LO load snapshots the upper half so the following HI load
    // pairs with it even if the low word carries in between.
    always_ff @(posedge clock) begin
        if (!rst) begin
            mtime           <= '0;
            mtime_hi_shadow <= '0;
            test_done       <= 1'b0;
            test_code       <= '0;
            access_fault    <= 1'b0;
        end else begin
            mtime        <= mtime + 64'd1;
            access_fault <= (mem_read || mem_write) &&
                            (misaligned || (region == REG_UNMAPPED));
            if (rd_ok && is_mmio && (offset == OFF_MTIME_LO))
                mtime_hi_shadow <= mtime[63:32];
            if (tohost_we && !test_done) begin
                test_code <= mem_write_data;
                test_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus randomized traffic,
// checked against a queue/array reference model of the memory map.
module tb_dmem_responder;

    localparam logic [31:0] MMIO      = 32'h1000_0000;
    localparam logic [31:0] RAM_BYTES = 32'd16384;

    logic        clock;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        console_ready;
    logic        test_done;
    logic [31:0] test_code;
    logic        access_fault;
    logic        fifo_overflow;

    dmem_responder dut (
        .clock          (clock),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .address        (address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .console_valid  (console_valid),
        .console_data   (console_data),
        .console_ready  (console_ready),
        .test_done      (test_done),
        .test_code      (test_code),
        .access_fault   (access_fault),
        .fifo_overflow  (fifo_overflow)
    );

    // Reference model state, advanced once per clock by modelEdge.
    logic [31:0] ram_m [int];
    logic [7:0]  fifo_m [$];
    logic [63:0] mtime_m;
    logic [31:0] shadow_m;
    logic [31:0] code_m;
    bit          done_m;
    bit          ovf_m;
    bit          fault_m;
    bit          synced;

    logic [31:0] rd_q [$];
    logic [7:0]  con_q [$];

    int vectors;
    int miscompares;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit isMmio(input logic [31:0] a);
        logic [31:0] off;
        off = a - MMIO;
        return (a >= MMIO) && (off <= 32'h10) && (off[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a);
        int n;
        n = fifo_m.size();
        if (a[1:0] != 2'b00)
            return 32'h0;
        if (a < RAM_BYTES)
            return ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'h0;
        case (a)
            MMIO + 32'h00: return code_m;
            MMIO + 32'h08: return {24'h0, 4'(n), ovf_m, (n == 8), (n == 0), 1'b0};
            MMIO + 32'h0C: return mtime_m[31:0];
            MMIO + 32'h10: return shadow_m;
            default:       return 32'h0;
        endcase
    endfunction

    task automatic modelEdge(input bit r, input bit rd, input bit wr, input bit rdy,
                             input logic [31:0] a, input logic [31:0] d);
        bit mis;
        bit mapped;
        bit pop;
        bit push;
        int pre_size;
        if (!r) begin
            mtime_m  = 64'h0;
            shadow_m = 32'h0;
            code_m   = 32'h0;
            done_m   = 1'b0;
            ovf_m    = 1'b0;
            fault_m  = 1'b0;
            fifo_m.delete();
            synced   = 1'b1;
            return;
        end
        mis      = (a[1:0] != 2'b00);
        mapped   = (a < RAM_BYTES) || isMmio(a);
        pre_size = fifo_m.size();
        pop      = rdy && (pre_size > 0);
        push     = wr && !mis && (a == MMIO + 32'h04);
        fault_m  = (rd || wr) && (mis || !mapped);
        if (rd && !mis && a == MMIO + 32'h0C)
            shadow_m = mtime_m[63:32];
        if (wr && !mis && a < RAM_BYTES)
            ram_m[int'(a >> 2)] = d;
        if (wr && !mis && a == MMIO && !done_m) begin
            code_m = d;
            done_m = 1'b1;
        end
        if (pop)
            void'(fifo_m.pop_front());
        if (push) begin
            if (pre_size == 8 && !pop)
                ovf_m = 1'b1;
            else
                fifo_m.push_back(d[7:0]);
        end
        mtime_m = mtime_m + 64'd1;
    endtask

    task automatic applyStimulus(input bit r, input bit rd, input bit wr, input bit rdy,
                                 input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        rst            = r;
        mem_read       = rd;
        mem_write      = wr;
        console_ready  = rdy;
        address        = a;
        mem_write_data = d;
        #1;
        if (synced) begin
            checkOutput("console_valid", console_valid, fifo_m.size() != 0);
            checkOutput("test_done", test_done, done_m);
            checkOutput("test_code", test_code, code_m);
            checkOutput("fifo_overflow", fifo_overflow, ovf_m);
            checkOutput("access_fault", access_fault, fault_m);
            if (!rd)
                checkOutput("rdata_idle", mem_read_data, 32'h0);
        end
        if (rd)
            rd_q.push_back(expRead(a));
        if (rdy && fifo_m.size() > 0)
            con_q.push_back(fifo_m[0]);
        modelEdge(r, rd, wr, rdy, a, d);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, rdy, 32'h0, 32'h0);
    endtask

    // Monitor: pairs each presented load or console handshake with its expectation.
    always @(negedge clock) begin
        #2;
        if (synced && mem_read) begin
            if (rd_q.size() == 0)
                checkOutput("rdata_unexpected", mem_read_data, 64'hDEAD_0000_0000_0000);
            else
                checkOutput("rdata", mem_read_data, rd_q.pop_front());
        end
        if (synced && console_valid && console_ready) begin
            if (con_q.size() == 0)
                checkOutput("console_unexpected", console_data, 64'h100);
            else
                checkOutput("console_data", console_data, con_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          idx;
        bit          r;
        bit          rd;
        bit          wr;
        bit          rdy;

        vectors        = 0;
        miscompares    = 0;
        synced         = 1'b0;
        rst            = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        console_ready  = 1'b0;
        address        = 32'h0;
        mem_write_data = 32'h0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h08, 32'h0);

        // RAM write/read, idle read data, read-during-write returns old word.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1234_5678);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, RAM_BYTES - 32'd4, 32'hCAFE_F00D);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, RAM_BYTES - 32'd4, 32'h0);

        // mtime after 100 idle cycles, then LO/HI coherence across a 64-bit wrap.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(100, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h0C, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h10, 32'h0);
        @(posedge clock);
        #1;
        force dut.mtime = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.mtime;
        mtime_m = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h0C, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h0C, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h10, 32'h0);

        // Console FIFO: overfill, drain, then full push+pop in one cycle.
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, MMIO + 32'h04, 32'h41 + i);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h08, 32'h0);
        idle(10, 1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, MMIO + 32'h04, 32'h61 + i);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, MMIO + 32'h04, 32'h5A);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO + 32'h08, 32'h0);
        idle(10, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, MMIO + 32'h04, 32'h77);
        idle(2, 1'b0);

        // tohost stickiness, then a reset that also flushes a queued byte.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, MMIO, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, MMIO, 32'h7);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, MMIO, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, MMIO + 32'h04, 32'h33);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, MMIO + 32'h04, 32'h44);
        idle(2, 1'b0);

        // Faults: misaligned load/store, unmapped store; RAM word 0 must survive.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h2000_0000, 32'h5555_5555);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h2, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, RAM_BYTES, 32'h0);
        idle(2, 1'b0);

        for (int n = 0; n < 500; n++) begin
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            a   = (idx < 8) ? 32'(idx * 4) : RAM_BYTES - 32'((idx - 7) * 4);
            d   = $urandom;
            rd  = 1'b0;
            wr  = 1'b0;
            rdy = $urandom_range(0, 1) == 1;
            r   = $urandom_range(0, 99) != 0;
            case (op)
                0, 1, 2: begin
                    wr = 1'b1;
                    rd = ram_m.exists(int'(a >> 2)) && ($urandom_range(0, 3) == 0);
                end
                3: begin
                    if (ram_m.exists(int'(a >> 2))) rd = 1'b1;
                    else wr = 1'b1;
                end
                4: begin
                    wr = 1'b1;
                    a  = MMIO + 32'h04;
                end
                5: begin
                    rd = 1'b1;
                    a  = MMIO + 32'(4 * $urandom_range(0, 4));
                end
                6: begin
                    case ($urandom_range(0, 3))
                        0: a = RAM_BYTES;
                        1: a = MMIO + 32'h14;
                        2: a = MMIO - 32'h4;
                        default: a = 32'hFFFF_FFFC;
                    endcase
                    rd = $urandom_range(0, 1) == 1;
                    wr = !rd;
                end
                7: begin
                    a  = a | 32'($urandom_range(1, 3));
                    rd = $urandom_range(0, 1) == 1;
                    wr = !rd;
                end
                8: begin
                    wr = 1'b1;
                    a  = MMIO;
                end
                default: ;
            endcase
            if (!r) rd = 1'b0;
            applyStimulus(r, rd, wr, rdy, a, d);
        end

        idle(12, 1'b1);
        idle(1, 1'b0);
        checkOutput("rd_queue_drained", rd_q.size(), 0);
        checkOutput("console_queue_drained", con_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
